// File: rtl/prf_scoreboard.sv
// Physical register file busy scoreboard with scheduled wakeups and same-cycle clear bypass.
// Optional checkpoint/restore of the busy vector when SCOREBOARD_CKPT_EN is defined.
module prf_scoreboard #(
   parameter int PRF_SIZE    = 64,
   parameter int SET_PORTS   = 4,
   parameter int CLR_PORTS   = 4,
   parameter int WAKE_PORTS  = 2,
   parameter int LAT_W       = 3,
   parameter int QUERY_PORTS = 16,
   parameter int CKPT_DEPTH  = 4,
   localparam int IDX_W      = $clog2(PRF_SIZE),
   localparam int CK_W       = $clog2(CKPT_DEPTH)
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           clear,
   input  logic [SET_PORTS-1:0]           set_busy_valid,
   input  logic [SET_PORTS*IDX_W-1:0]     set_busy_index,
   input  logic [CLR_PORTS-1:0]           clear_busy_valid,
   input  logic [CLR_PORTS*IDX_W-1:0]     clear_busy_index,
   input  logic [WAKE_PORTS-1:0]          wake_valid,
   input  logic [WAKE_PORTS*IDX_W-1:0]    wake_index,
   input  logic [WAKE_PORTS*LAT_W-1:0]    wake_latency,
   input  logic [QUERY_PORTS*IDX_W-1:0]   query_index,
   output logic [QUERY_PORTS-1:0]         query_busy,
   output logic [IDX_W:0]                 busy_count,
   input  logic                           ckpt_take,
   input  logic [CK_W-1:0]                ckpt_take_id,
   input  logic                           ckpt_restore,
   input  logic [CK_W-1:0]                ckpt_restore_id
);

   logic [PRF_SIZE-1:0] sb, sb_nxt, set_v, clr_v, wake_hit, expire, c_v, pend;
   logic [LAT_W-1:0]    cnt      [PRF_SIZE];
   logic [LAT_W-1:0]    wake_lat [PRF_SIZE];
   logic [IDX_W:0]      pop;

`ifdef SCOREBOARD_CKPT_EN
   logic [PRF_SIZE-1:0] slot [CKPT_DEPTH];
`else
   logic ckpt_unused;
   assign ckpt_unused = ^{ckpt_take, ckpt_take_id, ckpt_restore, ckpt_restore_id};
`endif

   always_comb begin
      set_v    = '0;
      clr_v    = '0;
      wake_hit = '0;
      for (int e = 0; e < PRF_SIZE; e++) wake_lat[e] = '0;
      for (int p = 0; p < SET_PORTS; p++)
         if (set_busy_valid[p]) set_v[set_busy_index[p*IDX_W +: IDX_W]] = 1'b1;
      for (int p = 0; p < CLR_PORTS; p++)
         if (clear_busy_valid[p]) clr_v[clear_busy_index[p*IDX_W +: IDX_W]] = 1'b1;
      // Walk downward so the lowest-numbered port is written last and wins.
      for (int p = WAKE_PORTS - 1; p >= 0; p--)
         if (wake_valid[p]) begin
            wake_hit[wake_index[p*IDX_W +: IDX_W]] = 1'b1;
            wake_lat[wake_index[p*IDX_W +: IDX_W]] = wake_latency[p*LAT_W +: LAT_W];
         end
      set_v[0] = 1'b0;
   end

   always_comb begin
      expire = '0;
      for (int e = 0; e < PRF_SIZE; e++)
         expire[e] = (pend[e] && cnt[e] == LAT_W'(1)) || (wake_hit[e] && wake_lat[e] == '0);
      c_v = clr_v | expire;
   end

   always_comb begin
      sb_nxt = (sb | set_v) & ~c_v;
`ifdef SCOREBOARD_CKPT_EN
      if (ckpt_restore) sb_nxt = slot[ckpt_restore_id] & ~c_v;
`endif
      sb_nxt[0] = 1'b0;
   end

   // Clears and expiries landing this cycle are hidden from inquiries immediately.
   always_comb begin
      query_busy = '0;
      for (int q = 0; q < QUERY_PORTS; q++)
         query_busy[q] = (query_index[q*IDX_W +: IDX_W] != '0) &&
                         sb[query_index[q*IDX_W +: IDX_W]] &&
                         !c_v[query_index[q*IDX_W +: IDX_W]];
   end

   always_comb begin
      pop = '0;
      for (int e = 0; e < PRF_SIZE; e++) pop = pop + {{IDX_W{1'b0}}, sb[e]};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sb         <= '0;
         busy_count <= '0;
      end else begin
         busy_count <= pop;
         sb         <= clear ? '0 : sb_nxt;
      end
   end

   always_ff @(posedge clock) begin
      for (int e = 0; e < PRF_SIZE; e++) begin
         if (reset || clear) begin
            pend[e] <= 1'b0;
            cnt[e]  <= '0;
         end else if (set_v[e] || clr_v[e]) begin
            pend[e] <= 1'b0;
         end else if (wake_hit[e]) begin
            pend[e] <= (wake_lat[e] != '0);
            cnt[e]  <= wake_lat[e];
         end else if (pend[e]) begin
            if (cnt[e] == LAT_W'(1)) pend[e] <= 1'b0;
            cnt[e] <= cnt[e] - LAT_W'(1);
         end
      end
   end

`ifdef SCOREBOARD_CKPT_EN
   // Written-back registers are scrubbed from every slot so a restore cannot revive them.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < CKPT_DEPTH; i++) slot[i] <= '0;
      end else begin
         for (int i = 0; i < CKPT_DEPTH; i++) slot[i] <= slot[i] & ~c_v;
         if (ckpt_take && !ckpt_restore) slot[ckpt_take_id] <= sb_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_prf_scoreboard.sv
// Directed bench for prf_scoreboard: set/clear/wakeup timing, bypass, cancel, clear, reset
// and (when SCOREBOARD_CKPT_EN is defined) checkpoint restore.
module tb_prf_scoreboard;
   localparam int IW = 6;
   localparam int LW = 3;
   localparam int CW = 2;

   logic            clock, reset, clear;
   logic [3:0]      set_busy_valid, clear_busy_valid;
   logic [4*IW-1:0] set_busy_index, clear_busy_index;
   logic [1:0]      wake_valid;
   logic [2*IW-1:0] wake_index;
   logic [2*LW-1:0] wake_latency;
   logic [16*IW-1:0] query_index;
   logic [15:0]     query_busy;
   logic [IW:0]     busy_count;
   logic            ckpt_take, ckpt_restore;
   logic [CW-1:0]   ckpt_take_id, ckpt_restore_id;

   int cmp_cnt = 0;
   int err_cnt = 0;

   prf_scoreboard dut (
      .clock(clock), .reset(reset), .clear(clear),
      .set_busy_valid(set_busy_valid), .set_busy_index(set_busy_index),
      .clear_busy_valid(clear_busy_valid), .clear_busy_index(clear_busy_index),
      .wake_valid(wake_valid), .wake_index(wake_index), .wake_latency(wake_latency),
      .query_index(query_index), .query_busy(query_busy), .busy_count(busy_count),
      .ckpt_take(ckpt_take), .ckpt_take_id(ckpt_take_id),
      .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic idle();
      clear = 0; set_busy_valid = '0; clear_busy_valid = '0; wake_valid = '0;
      ckpt_take = 0; ckpt_restore = 0; ckpt_take_id = '0; ckpt_restore_id = '0;
   endtask

   task automatic nxt();
      @(posedge clock); #1; idle();
   endtask

   task automatic sset(input int p, input int idx);
      set_busy_valid[p] = 1'b1; set_busy_index[p*IW +: IW] = IW'(idx);
   endtask

   task automatic clb(input int p, input int idx);
      clear_busy_valid[p] = 1'b1; clear_busy_index[p*IW +: IW] = IW'(idx);
   endtask

   task automatic wk(input int p, input int idx, input int lat);
      wake_valid[p] = 1'b1; wake_index[p*IW +: IW] = IW'(idx);
      wake_latency[p*LW +: LW] = LW'(lat);
   endtask

   task automatic qry(input int p, input int idx);
      query_index[p*IW +: IW] = IW'(idx);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      idle(); reset = 1; query_index = '0;
      set_busy_index = '0; clear_busy_index = '0; wake_index = '0; wake_latency = '0;
      repeat (2) @(posedge clock);
      #1 reset = 0;
      qry(0, 5); qry(1, 7);
      @(negedge clock);
      chk("rst_count", 32'(busy_count), 0);
      chk("rst_query", 32'(query_busy), 0);

      // set 5: invisible this cycle, busy next, counted the cycle after
      nxt(); sset(0, 5); qry(0, 5); @(negedge clock);
      chk("set_same_cyc", 32'(query_busy[0]), 0);
      chk("cnt_a", 32'(busy_count), 0);
      nxt(); @(negedge clock);
      chk("set_next_cyc", 32'(query_busy[0]), 1);
      chk("cnt_b", 32'(busy_count), 0);

      // set+clear on 7, set on 0, duplicate set of 10
      nxt(); sset(0, 7); sset(1, 0); sset(2, 10); sset(3, 10); clb(0, 7);
      qry(1, 7); qry(2, 0); @(negedge clock);
      chk("q5_c", 32'(query_busy[0]), 1);
      chk("q7_c", 32'(query_busy[1]), 0);
      chk("q0_c", 32'(query_busy[2]), 0);
      chk("cnt_c", 32'(busy_count), 1);
      nxt(); qry(3, 10); @(negedge clock);
      chk("clr_wins_7", 32'(query_busy[1]), 0);
      chk("idx0_never", 32'(query_busy[2]), 0);
      chk("dup_set_10", 32'(query_busy[3]), 1);
      chk("cnt_d", 32'(busy_count), 1);
      nxt(); sset(0, 9); @(negedge clock);
      chk("cnt_e", 32'(busy_count), 2);

      // wake 9 with latency 3 at cycle F: busy F..F+2, bypassed at F+3
      nxt(); wk(0, 9, 3); qry(0, 9); @(negedge clock);
      chk("wk9_t0", 32'(query_busy[0]), 1);
      nxt(); @(negedge clock); chk("wk9_t1", 32'(query_busy[0]), 1);
      nxt(); @(negedge clock); chk("wk9_t2", 32'(query_busy[0]), 1);
      nxt(); @(negedge clock); chk("wk9_t3_bypass", 32'(query_busy[0]), 0);
      nxt(); @(negedge clock);
      chk("wk9_t4", 32'(query_busy[0]), 0);
      chk("cnt_j", 32'(busy_count), 3);

      // clear_busy bypass and zero-latency wake
      nxt(); clb(0, 5); wk(0, 10, 0); qry(0, 5); qry(1, 10); @(negedge clock);
      chk("clr_bypass_5", 32'(query_busy[0]), 0);
      chk("wk_l0_bypass", 32'(query_busy[1]), 0);
      chk("cnt_k", 32'(busy_count), 2);
      nxt(); sset(0, 12); @(negedge clock);
      chk("cnt_l", 32'(busy_count), 2);

      // two wakes on 12 in one cycle: port 0 (latency 2) wins over port 1 (latency 0)
      nxt(); wk(0, 12, 2); wk(1, 12, 0); qry(0, 12); @(negedge clock);
      chk("wk_prio_t0", 32'(query_busy[0]), 1);
      chk("cnt_m", 32'(busy_count), 0);
      nxt(); @(negedge clock); chk("wk_prio_t1", 32'(query_busy[0]), 1);
      nxt(); @(negedge clock); chk("wk_prio_t2", 32'(query_busy[0]), 0);

      // wake 4 latency 5, re-set 4 two cycles later cancels the countdown
      nxt(); sset(0, 4); @(negedge clock);
      nxt(); wk(0, 4, 5); qry(0, 4); @(negedge clock);
      chk("wk4_t0", 32'(query_busy[0]), 1);
      nxt();
      nxt(); sset(0, 4);
      for (int k = 0; k < 7; k++) begin
         nxt(); @(negedge clock);
         chk("cancel_4", 32'(query_busy[0]), 1);
      end

      // ten busy entries then flush
      for (int k = 0; k < 3; k++) begin
         nxt();
         for (int p = 0; p < 3; p++) sset(p, 20 + 3*k + p);
      end
      nxt();
      nxt(); clear = 1; qry(0, 4); qry(1, 20); qry(2, 28); @(negedge clock);
      chk("cnt_pre_clear", 32'(busy_count), 10);
      nxt(); @(negedge clock);
      chk("clear_q", 32'(query_busy[2:0]), 0);
      nxt(); @(negedge clock);
      chk("clear_cnt", 32'(busy_count), 0);

`ifdef SCOREBOARD_CKPT_EN
      nxt(); sset(0, 3); sset(1, 6);
      nxt(); ckpt_take = 1; ckpt_take_id = 2'd1;
      nxt(); sset(0, 8); clb(0, 6);
      nxt(); ckpt_restore = 1; ckpt_restore_id = 2'd1;
      nxt(); qry(0, 3); qry(1, 6); qry(2, 8); @(negedge clock);
      chk("ckpt_q3", 32'(query_busy[0]), 1);
      chk("ckpt_q6", 32'(query_busy[1]), 0);
      chk("ckpt_q8", 32'(query_busy[2]), 0);
`endif

      // reset in the middle of a countdown
      nxt(); sset(0, 40); sset(1, 41);
      nxt(); wk(0, 40, 4); qry(0, 40); qry(1, 41); @(negedge clock);
      chk("pre_rst_q40", 32'(query_busy[0]), 1);
      nxt(); reset = 1;
      nxt(); reset = 0; @(negedge clock);
      chk("post_rst_q", 32'(query_busy[1:0]), 0);
      nxt(); @(negedge clock);
      chk("post_rst_cnt", 32'(busy_count), 0);
      for (int k = 0; k < 4; k++) begin
         nxt(); @(negedge clock);
         chk("post_rst_idle", 32'(query_busy[1:0]), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end
endmodule
